// File: rtl/uart_rx_oversampled_if.sv
// Write-side FIFO and status strobes of the oversampling UART receiver.
// The receiver is the master; the downstream FIFO/status consumer is the slave.
interface uart_rx_oversampled_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_o;
    logic                 wr_en_o;
    logic                 fifo_full_i;
    logic                 frame_err_o;
    logic                 parity_err_o;
    logic                 overrun_o;
    logic                 busy_o;

    modport master (
        input  fifo_full_i,
        output data_o, wr_en_o, frame_err_o, parity_err_o, overrun_o, busy_o
    );

    modport slave (
        output fifo_full_i,
        input  data_o, wr_en_o, frame_err_o, parity_err_o, overrun_o, busy_o
    );
endinterface

// File: rtl/uart_rx_oversampled.sv
// Oversampling UART receiver with majority-vote sampling, false-start rejection
// and frame/parity/overrun reporting; good words are written to a FIFO.
module uart_rx_oversampled #(
    parameter int CLK_FREQ   = 18_432_000,
    parameter int BAUD       = 115_200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_i,
    uart_rx_oversampled_if.master fifo
);

    localparam int DIV  = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int M    = OVERSAMPLE / 2;
    localparam int TC_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SC_W = $clog2(OVERSAMPLE);
    localparam int BC_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    generate
        if (DIV < 1 || OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_param_check
            $error("uart_rx_oversampled: need DIV >= 1 and an even OVERSAMPLE >= 4");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, WAIT_HIGH
    } state_t;

    state_t               state;
    logic                 rx_meta_p0;
    logic                 rxs;
    logic                 rxs_prev;
    logic [TC_W-1:0]      tc;
    logic [SC_W-1:0]      sc;
    logic [BC_W-1:0]      bc;
    logic                 s0;
    logic                 s1;
    logic                 par_err;
    logic [DATA_BITS-1:0] shreg;

    logic tick;
    logic start_edge;
    logic vote;
    logic at_vote;
    logic bit_end;

    // Synchronizer flops reset high so the idle line shows no edge after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_p0 <= 1'b1;
            rxs        <= 1'b1;
            rxs_prev   <= 1'b1;
        end else begin
            rx_meta_p0 <= rx_i;
            rxs        <= rx_meta_p0;
            rxs_prev   <= rxs;
        end
    end

    assign tick       = (tc == TC_W'(DIV - 1));
    assign start_edge = (state == IDLE) && rxs_prev && !rxs;
    assign vote       = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
    assign at_vote    = tick && (sc == SC_W'(M + 1));
    assign bit_end    = tick && (sc == SC_W'(OVERSAMPLE - 1));

    // Tick phase is realigned to the start edge so sampling stays centred
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tc <= '0;
        end else if (start_edge || tick) begin
            tc <= '0;
        end else begin
            tc <= tc + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (state == DATA && at_vote) begin
            shreg <= {vote, shreg[DATA_BITS-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            sc                <= '0;
            bc                <= '0;
            s0                <= 1'b0;
            s1                <= 1'b0;
            par_err           <= 1'b0;
            fifo.data_o       <= '0;
            fifo.wr_en_o      <= 1'b0;
            fifo.frame_err_o  <= 1'b0;
            fifo.parity_err_o <= 1'b0;
            fifo.overrun_o    <= 1'b0;
            fifo.busy_o       <= 1'b0;
        end else begin
            fifo.wr_en_o      <= 1'b0;
            fifo.frame_err_o  <= 1'b0;
            fifo.parity_err_o <= 1'b0;
            fifo.overrun_o    <= 1'b0;

            if (state != IDLE && tick) begin
                sc <= (sc == SC_W'(OVERSAMPLE - 1)) ? '0 : sc + 1'b1;
                if (sc == SC_W'(M - 1)) s0 <= rxs;
                if (sc == SC_W'(M))     s1 <= rxs;
            end

            case (state)
                IDLE: begin
                    if (start_edge) begin
                        state       <= START;
                        sc          <= '0;
                        bc          <= '0;
                        par_err     <= 1'b0;
                        fifo.busy_o <= 1'b1;
                    end
                end
                START: begin
                    if (at_vote && vote) begin
                        state       <= IDLE;
                        fifo.busy_o <= 1'b0;
                    end else if (bit_end) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bc == BC_W'(DATA_BITS - 1)) begin
                            bc    <= '0;
                            state <= (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            bc <= bc + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (at_vote) begin
                        par_err <= vote ^ (^shreg) ^ (PARITY_ODD != 0);
                    end
                    if (bit_end) begin
                        state <= STOP;
                    end
                end
                // Leave mid stop bit so a back-to-back start edge is not missed
                STOP: begin
                    if (at_vote) begin
                        if (!vote) begin
                            fifo.frame_err_o <= 1'b1;
                            state            <= WAIT_HIGH;
                        end else begin
                            state       <= IDLE;
                            fifo.busy_o <= 1'b0;
                            if (par_err) begin
                                fifo.parity_err_o <= 1'b1;
                            end else if (fifo.fifo_full_i) begin
                                fifo.overrun_o <= 1'b1;
                            end else begin
                                fifo.wr_en_o <= 1'b1;
                                fifo.data_o  <= shreg;
                            end
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (rxs) begin
                        state       <= IDLE;
                        fifo.busy_o <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    fifo.busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Bench for uart_rx_oversampled: an 8N1 instance and an 8E1 instance driven
// by a bit-level line driver, with outcomes predicted from the frame contents.
module tb_uart_rx_oversampled;

    localparam int BIT_CLK = 160;

    typedef struct {
        int         kind;   // 0 write, 1 frame error, 2 parity error, 3 overrun
        logic [7:0] data;
        int         cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx0 = 1'b1;
    logic rx1 = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   multi_cnt = 0;
    int   last_fall = 0;
    ev_t  q0[$];
    ev_t  q1[$];

    uart_rx_oversampled_if #(.DATA_BITS(8)) if0 ();
    uart_rx_oversampled_if #(.DATA_BITS(8)) if1 ();

    uart_rx_oversampled #(.PARITY_EN(0)) dut0 (
        .clk(clk), .rst(rst), .rx_i(rx0), .fifo(if0.master)
    );
    uart_rx_oversampled #(.PARITY_EN(1), .PARITY_ODD(0)) dut1 (
        .clk(clk), .rst(rst), .rx_i(rx1), .fifo(if1.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if ((int'(if0.wr_en_o) + int'(if0.frame_err_o) + int'(if0.parity_err_o) + int'(if0.overrun_o)) > 1 ||
                (int'(if1.wr_en_o) + int'(if1.frame_err_o) + int'(if1.parity_err_o) + int'(if1.overrun_o)) > 1)
                multi_cnt++;
            if (if0.wr_en_o)      q0.push_back('{kind: 0, data: if0.data_o, cyc: cyc});
            if (if0.frame_err_o)  q0.push_back('{kind: 1, data: 8'h00, cyc: cyc});
            if (if0.parity_err_o) q0.push_back('{kind: 2, data: 8'h00, cyc: cyc});
            if (if0.overrun_o)    q0.push_back('{kind: 3, data: 8'h00, cyc: cyc});
            if (if1.wr_en_o)      q1.push_back('{kind: 0, data: if1.data_o, cyc: cyc});
            if (if1.frame_err_o)  q1.push_back('{kind: 1, data: 8'h00, cyc: cyc});
            if (if1.parity_err_o) q1.push_back('{kind: 2, data: 8'h00, cyc: cyc});
            if (if1.overrun_o)    q1.push_back('{kind: 3, data: 8'h00, cyc: cyc});
        end
    end

    // Outcome of one frame from its contents: frame > parity > overrun > write
    function automatic int model_kind(input logic [7:0] d, input bit has_par, input bit pbit,
                                      input bit odd, input bit stop, input bit full);
        int ones;
        ones = $countones(d);
        if (!stop) return 1;
        if (has_par && (pbit != ((ones % 2 == 1) != odd))) return 2;
        if (full) return 3;
        return 0;
    endfunction

    task automatic drive(input int which, input logic v);
        if (which == 0) rx0 = v;
        else            rx1 = v;
    endtask

    task automatic idle_bits(input int which, input int n);
        drive(which, 1'b1);
        repeat (n * BIT_CLK) @(negedge clk);
    endtask

    task automatic send_frame(input int which, input logic [7:0] d, input bit has_par,
                              input bit pbit, input bit stop, input bit full);
        if (which == 0) if0.fifo_full_i = full;
        else            if1.fifo_full_i = full;
        drive(which, 1'b0);
        last_fall = cyc;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            drive(which, d[i]);
            repeat (BIT_CLK) @(negedge clk);
        end
        if (has_par) begin
            drive(which, pbit);
            repeat (BIT_CLK) @(negedge clk);
        end
        drive(which, stop);
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic test_reset;
        if0.fifo_full_i = 1'b0;
        if1.fifo_full_i = 1'b0;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if ({if0.wr_en_o, if0.frame_err_o, if0.parity_err_o, if0.overrun_o, if0.busy_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_strobes0: got %b expected 00000",
                     {if0.wr_en_o, if0.frame_err_o, if0.parity_err_o, if0.overrun_o, if0.busy_o});
        end
        checks++;
        if (if0.data_o !== 8'h00) begin
            errors++;
            $display("FAIL reset_data0: got %h expected 00", if0.data_o);
        end
        checks++;
        if ({if1.wr_en_o, if1.frame_err_o, if1.parity_err_o, if1.overrun_o, if1.busy_o, if1.data_o} !== 13'b0) begin
            errors++;
            $display("FAIL reset_outputs1: got %b expected all zero",
                     {if1.wr_en_o, if1.frame_err_o, if1.parity_err_o, if1.overrun_o, if1.busy_o, if1.data_o});
        end
        rst = 1'b0;
        repeat (50) @(negedge clk);
        checks++;
        if (if0.busy_o !== 1'b0 || if1.busy_o !== 1'b0 || q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL reset_release: busy %b/%b events %0d/%0d expected idle with no events",
                     if0.busy_o, if1.busy_o, q0.size(), q1.size());
        end
    endtask

    task automatic test_single_frame;
        q0.delete();
        send_frame(0, 8'hA5, 0, 0, 1, 0);
        repeat (20) @(negedge clk);
        checks++;
        if (q0.size() != 1) begin
            errors++;
            $display("FAIL single_count: got %0d events expected 1", q0.size());
        end else begin
            checks++;
            if (q0[0].kind != 0 || q0[0].data !== 8'hA5) begin
                errors++;
                $display("FAIL single_word: got kind %0d data %h expected kind 0 data a5",
                         q0[0].kind, q0[0].data);
            end
            checks++;
            if ((q0[0].cyc - last_fall) < 1530 || (q0[0].cyc - last_fall) > 1560) begin
                errors++;
                $display("FAIL single_latency: got %0d clk expected 1530..1560", q0[0].cyc - last_fall);
            end
        end
        checks++;
        if (if0.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL single_busy: got %b expected 0", if0.busy_o);
        end
        checks++;
        if (if0.data_o !== 8'hA5) begin
            errors++;
            $display("FAIL single_hold: got %h expected a5", if0.data_o);
        end
    endtask

    task automatic test_glitch;
        q0.delete();
        drive(0, 1'b0);
        repeat (20) @(negedge clk);
        checks++;
        if (if0.busy_o !== 1'b1) begin
            errors++;
            $display("FAIL glitch_busy_high: got %b expected 1", if0.busy_o);
        end
        repeat (20) @(negedge clk);
        drive(0, 1'b1);
        repeat (100) @(negedge clk);
        checks++;
        if (if0.busy_o !== 1'b0 || q0.size() != 0) begin
            errors++;
            $display("FAIL glitch_reject: busy %b events %0d expected busy 0 events 0",
                     if0.busy_o, q0.size());
        end
        idle_bits(0, 1);
    endtask

    task automatic test_frame_error;
        q0.delete();
        send_frame(0, 8'h3C, 0, 0, 0, 0);
        repeat (2 * BIT_CLK) @(negedge clk);
        checks++;
        if (q0.size() != 1 || q0[0].kind != model_kind(8'h3C, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL break_single_frame_err: got %0d events (first kind %0d) expected one kind 1",
                     q0.size(), (q0.size() > 0) ? q0[0].kind : -1);
        end
        idle_bits(0, 1);
        q0.delete();
        send_frame(0, 8'h55, 0, 0, 1, 0);
        repeat (20) @(negedge clk);
        checks++;
        if (q0.size() != 1 || q0[0].kind != 0 || q0[0].data !== 8'h55) begin
            errors++;
            $display("FAIL after_break_word: got %0d events data %h expected one write of 55",
                     q0.size(), if0.data_o);
        end
    endtask

    task automatic test_parity;
        ev_t        exp[$];
        logic [7:0] d;
        bit         pbit;
        bit         stop;
        bit         full;
        q1.delete();
        send_frame(1, 8'h01, 1, 0, 1, 0);
        idle_bits(1, 1);
        send_frame(1, 8'h01, 1, 1, 1, 0);
        idle_bits(1, 1);
        checks++;
        if (q1.size() != 2) begin
            errors++;
            $display("FAIL parity_fixed_count: got %0d events expected 2", q1.size());
        end else begin
            checks++;
            if (q1[0].kind != 2) begin
                errors++;
                $display("FAIL parity_bad_bit: got kind %0d expected 2", q1[0].kind);
            end
            checks++;
            if (q1[1].kind != 0 || q1[1].data !== 8'h01) begin
                errors++;
                $display("FAIL parity_good_bit: got kind %0d data %h expected kind 0 data 01",
                         q1[1].kind, q1[1].data);
            end
        end
        q1.delete();
        for (int n = 0; n < 6; n++) begin
            d    = 8'($urandom);
            pbit = 1'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            full = 1'($urandom);
            exp.push_back('{kind: model_kind(d, 1, pbit, 0, stop, full), data: d, cyc: 0});
            send_frame(1, d, 1, pbit, stop, full);
            idle_bits(1, 1);
        end
        if1.fifo_full_i = 1'b0;
        checks++;
        if (q1.size() != exp.size()) begin
            errors++;
            $display("FAIL parity_rand_count: got %0d events expected %0d", q1.size(), exp.size());
        end else begin
            foreach (exp[i]) begin
                checks++;
                if (q1[i].kind != exp[i].kind || (exp[i].kind == 0 && q1[i].data !== exp[i].data)) begin
                    errors++;
                    $display("FAIL parity_rand_%0d: got kind %0d data %h expected kind %0d data %h",
                             i, q1[i].kind, q1[i].data, exp[i].kind, exp[i].data);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        ev_t        exp[$];
        logic [7:0] d;
        bit         full;
        logic [7:0] fixed_d[3];
        bit         fixed_f[3];
        fixed_d = '{8'h00, 8'hFF, 8'h80};
        fixed_f = '{1'b0, 1'b1, 1'b0};
        q0.delete();
        for (int n = 0; n < 7; n++) begin
            if (n < 3) begin
                d    = fixed_d[n];
                full = fixed_f[n];
            end else begin
                d    = 8'($urandom);
                full = ($urandom_range(0, 2) == 0);
            end
            exp.push_back('{kind: model_kind(d, 0, 0, 0, 1, full), data: d, cyc: 0});
            send_frame(0, d, 0, 0, 1, full);
        end
        if0.fifo_full_i = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (q0.size() != exp.size()) begin
            errors++;
            $display("FAIL b2b_count: got %0d events expected %0d", q0.size(), exp.size());
        end else begin
            foreach (exp[i]) begin
                checks++;
                if (q0[i].kind != exp[i].kind || (exp[i].kind == 0 && q0[i].data !== exp[i].data)) begin
                    errors++;
                    $display("FAIL b2b_%0d: got kind %0d data %h expected kind %0d data %h",
                             i, q0[i].kind, q0[i].data, exp[i].kind, exp[i].data);
                end
            end
        end
        idle_bits(0, 1);
    endtask

    task automatic test_reset_midframe;
        logic [7:0] d;
        d = 8'h5A;
        q0.delete();
        drive(0, 1'b0);
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            drive(0, d[i]);
            repeat (BIT_CLK) @(negedge clk);
        end
        drive(0, d[4]);
        repeat (BIT_CLK / 2) @(negedge clk);
        checks++;
        if (if0.busy_o !== 1'b1) begin
            errors++;
            $display("FAIL midframe_busy: got %b expected 1", if0.busy_o);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({if0.wr_en_o, if0.frame_err_o, if0.parity_err_o, if0.overrun_o, if0.busy_o, if0.data_o} !== 13'b0) begin
            errors++;
            $display("FAIL midframe_reset_outputs: got %b expected all zero",
                     {if0.wr_en_o, if0.frame_err_o, if0.parity_err_o, if0.overrun_o, if0.busy_o, if0.data_o});
        end
        repeat (5) @(negedge clk);
        rst = 1'b0;
        idle_bits(0, 2);
        checks++;
        if (q0.size() != 0 || if0.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL midframe_no_strobe: got %0d events busy %b expected 0 events busy 0",
                     q0.size(), if0.busy_o);
        end
        send_frame(0, 8'h5A, 0, 0, 1, 0);
        repeat (20) @(negedge clk);
        checks++;
        if (q0.size() != 1 || q0[0].kind != 0 || q0[0].data !== 8'h5A) begin
            errors++;
            $display("FAIL midframe_next_word: got %0d events data %h expected one write of 5a",
                     q0.size(), if0.data_o);
        end
    endtask

    task automatic test_strobe_exclusive;
        checks++;
        if (multi_cnt != 0) begin
            errors++;
            $display("FAIL strobe_exclusive: got %0d cycles with several strobes expected 0", multi_cnt);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_single_frame;
        test_glitch;
        test_frame_error;
        test_parity;
        test_back_to_back;
        test_reset_midframe;
        test_strobe_exclusive;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_oversampled.md
Name: uart_rx_oversampled

Overview:
- Oversampling UART receiver that deserializes `rx_i` into bytes and pushes them into a downstream write-side FIFO interface.
- Generates its own sample tick internally; only `CLK_FREQ` and `BAUD` are needed.
- Uses majority-vote sampling and detects false starts, framing, parity and overrun errors.
- Intended as the hardened receive path alongside the existing serializer in the UART wrappers.

Parameters:
- CLK_FREQ, 18_432_000, system clock frequency in Hz.
- BAUD, 115_200, line rate in bits/s.
- OVERSAMPLE, 16, samples per bit; must be ≥ 4 and even.
- DATA_BITS, 8, data bits per frame, LSB first.
- PARITY_EN, 0, 1 = a parity bit follows the data bits.
- PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN = 0.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rx_i  in  1  serial line, idle high, asynchronous to clk.
- fifo_full_i  in  1  downstream FIFO full.
- data_o  out  DATA_BITS  received word; valid while wr_en_o = 1.
- wr_en_o  out  1  single-cycle FIFO write strobe.
- frame_err_o  out  1  single-cycle pulse: stop bit sampled low.
- parity_err_o  out  1  single-cycle pulse: parity mismatch.
- overrun_o  out  1  single-cycle pulse: good frame dropped because fifo_full_i = 1.
- busy_o  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- One clock domain (clk); reset is asynchronous and active-high.
- Reset values:
  - all outputs 0, data_o = 0;
  - rx synchronizer flops = 1, so no false start is seen out of reset;
  - FSM = IDLE, all counters = 0.
- rx_i passes through a 2-FF synchronizer; all logic uses the synchronized value `rxs`.
- Tick generator:
  - DIV = CLK_FREQ / (BAUD*OVERSAMPLE), integer floor; elaboration error if DIV < 1.
  - Tick counter runs 0..DIV-1 and pulses a tick at DIV-1.
  - Counter is cleared on start-edge detection.
- Sample counter `sc` runs 0..OVERSAMPLE-1 per bit and advances on each tick.
- Majority vote of the samples at sc = M-1, M, M+1 (M = OVERSAMPLE/2); the decision is made at sc = M+1.
- FSM states:
  - IDLE: on `rxs` 1→0 (registered previous value), clear tick counter and sc → START.
  - START: at the vote, result 1 → IDLE (false start, no output); result 0 → continue. At sc = OVERSAMPLE-1 → DATA.
  - DATA: vote shifts into the shift register LSB first. After DATA_BITS bits → PARITY if PARITY_EN, else STOP.
  - PARITY: vote is compared against the computed parity; the mismatch is latched. At bit end → STOP.
  - STOP: at the vote, result 0 → frame_err_o pulse, no write → WAIT_HIGH. Result 1 → evaluate, then → IDLE immediately (mid stop bit, allows back-to-back frames).
  - WAIT_HIGH: stay until `rxs` = 1, then → IDLE. A continuous low (break) produces exactly one frame_err_o.
- STOP evaluation when the stop bit is good:
  - parity mismatch → parity_err_o pulse, no write;
  - else fifo_full_i = 1 → overrun_o pulse, no write;
  - else wr_en_o pulse with data_o = shift register.
- Output timing: all outputs are registered and asserted the clk cycle after the stop-bit vote tick. data_o holds its value until the next write.
- Error precedence: frame > parity > overrun. At most one of the four strobes is high in any cycle.
- fifo_full_i is sampled only in the evaluation cycle. It has no backpressure effect on reception.
- Reset mid-frame: immediate return to IDLE, no strobe produced. A low rx after reset release is treated as a new start edge only after a 1→0 transition.

Test Plan:
- Default params (DIV = 10, 160 clk/bit), send 0xA5 8N1 → exactly one wr_en_o with data_o = 0xA5, occurring 1530–1560 clk after the rx_i falling edge; busy_o low afterwards.
- Low glitch of 40 clk on an idle line → no strobe; busy_o returns to 0 within 100 clk.
- Send 0x3C with stop bit 0, then hold rx_i low for 2 bit times → one frame_err_o, no wr_en_o. A following 0x55 after rx_i returns high → data_o = 0x55.
- PARITY_EN = 1, even parity: send 0x01 with parity bit 0 → parity_err_o only. Send 0x01 with parity bit 1 → write of 0x01.
- Back-to-back 0x00, 0xFF, 0x80 with no idle gap; fifo_full_i = 1 during the second frame → writes of 0x00 and 0x80, one overrun_o pulse.
- Assert rst during bit 4 of a frame → all outputs 0 immediately, no strobe. Next full frame 0x5A → write of 0x5A.
